// File: rtl/bus_snoop_responder.sv
// Snoop responder for an LLC bus port: accepts one bus operation at a time,
// spends a fixed snoop window (plus a write-back window on dirty read hits),
// then holds the snoop result until the LLC consumes it.
module bus_snoop_responder #(
    parameter int ADDR_BITS     = 32,
    parameter int SNOOP_LATENCY = 2,
    parameter int HITM_EXTRA    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bus_req_valid,
    output logic                 bus_req_ready,
    input  logic [1:0]           bus_op,
    input  logic [ADDR_BITS-1:0] bus_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_snoop,
    output logic [1:0]           rsp_op,
    output logic [ADDR_BITS-1:0] rsp_addr,
    output logic [31:0]          read_cnt,
    output logic [31:0]          write_cnt,
    output logic [31:0]          inval_cnt,
    output logic [31:0]          rwim_cnt,
    output logic [31:0]          hitm_cnt
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SNOOP     = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] RESPOND   = 2'd3;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INVAL = 2'd2;
    localparam logic [1:0] OP_RWIM  = 2'd3;

    localparam logic [1:0] SNP_HIT   = 2'd0;
    localparam logic [1:0] SNP_HITM  = 2'd1;
    localparam logic [1:0] SNP_NOHIT = 2'd2;

    localparam logic [3:0] SNOOP_LOAD = 4'(SNOOP_LATENCY - 1);
    localparam logic [3:0] WB_LOAD    = 4'(HITM_EXTRA - 1);

    logic [1:0]           state_r;
    logic [1:0]           state_next_s;
    logic [3:0]           cnt_r;
    logic [1:0]           op_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [1:0]           snoop_r;
    logic [1:0]           snoop_s;
    logic                 wb_s;

    // Statistics never wrap: they stick at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [1:0] snoop_of(input logic [1:0] a);
        logic [1:0] r;
        case (a)
            2'b00:   r = SNP_HIT;
            2'b01:   r = SNP_HITM;
            default: r = SNP_NOHIT;
        endcase
        return r;
    endfunction

    // Snoop decode of the captured address and next-state selection.
    always_comb begin
        snoop_s      = snoop_of(addr_r[1:0]);
        wb_s         = (snoop_s == SNP_HITM) && ((op_r == OP_READ) || (op_r == OP_RWIM));
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus_req_valid) state_next_s = SNOOP;
                else               state_next_s = IDLE;
            end
            SNOOP: begin
                if (cnt_r == 4'd0) state_next_s = wb_s ? WRITEBACK : RESPOND;
                else               state_next_s = SNOOP;
            end
            WRITEBACK: begin
                if (cnt_r == 4'd0) state_next_s = RESPOND;
                else               state_next_s = WRITEBACK;
            end
            RESPOND: begin
                if (rsp_ready) state_next_s = IDLE;
                else           state_next_s = RESPOND;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, capture, response and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            bus_req_ready <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_snoop     <= SNP_NOHIT;
            rsp_op        <= 2'd0;
            rsp_addr      <= '0;
            cnt_r         <= 4'd0;
            op_r          <= 2'd0;
            addr_r        <= '0;
            snoop_r       <= SNP_NOHIT;
            read_cnt      <= 32'd0;
            write_cnt     <= 32'd0;
            inval_cnt     <= 32'd0;
            rwim_cnt      <= 32'd0;
            hitm_cnt      <= 32'd0;
        end else begin
            state_r       <= state_next_s;
            bus_req_ready <= (state_next_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (bus_req_valid) begin
                        op_r   <= bus_op;
                        addr_r <= bus_addr;
                        cnt_r  <= SNOOP_LOAD;
                        case (bus_op)
                            OP_READ:  read_cnt  <= sat_inc(read_cnt);
                            OP_WRITE: write_cnt <= sat_inc(write_cnt);
                            OP_INVAL: inval_cnt <= sat_inc(inval_cnt);
                            OP_RWIM:  rwim_cnt  <= sat_inc(rwim_cnt);
                            default:  read_cnt  <= read_cnt;
                        endcase
                    end
                end
                SNOOP: begin
                    if (cnt_r == 4'd0) begin
                        snoop_r <= snoop_s;
                        if (wb_s) begin
                            cnt_r <= WB_LOAD;
                        end else begin
                            // Outputs only change when a new result is presented.
                            rsp_valid <= 1'b1;
                            rsp_snoop <= snoop_s;
                            rsp_op    <= op_r;
                            rsp_addr  <= addr_r;
                            if (snoop_s == SNP_HITM) hitm_cnt <= sat_inc(hitm_cnt);
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                WRITEBACK: begin
                    if (cnt_r == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_snoop <= snoop_r;
                        rsp_op    <= op_r;
                        rsp_addr  <= addr_r;
                        if (snoop_r == SNP_HITM) hitm_cnt <= sat_inc(hitm_cnt);
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_snoop_responder.sv
// Bench for bus_snoop_responder: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a timing-level model.
module tb_bus_snoop_responder;

    localparam int SL = 2;
    localparam int HE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_snoop;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_addr;
    logic [31:0] read_cnt, write_cnt, inval_cnt, rwim_cnt, hitm_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic check_en = 1'b0;
    logic force_pulse = 1'b0;

    bus_snoop_responder #(.ADDR_BITS(32), .SNOOP_LATENCY(SL), .HITM_EXTRA(HE)) dut (
        .clk(clk), .rst(rst),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_op(bus_op), .bus_addr(bus_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_snoop(rsp_snoop), .rsp_op(rsp_op), .rsp_addr(rsp_addr),
        .read_cnt(read_cnt), .write_cnt(write_cnt), .inval_cnt(inval_cnt),
        .rwim_cnt(rwim_cnt), .hitm_cnt(hitm_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] snoop_of(input logic [1:0] a);
        return (a == 2'd0) ? 2'd0 : ((a == 2'd1) ? 2'd1 : 2'd2);
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Model: a request is either absent, waiting for its response time, or presented.
    int          cyc = 0;
    int          m_resp_at = 0;
    logic        m_busy, m_ready, m_valid;
    logic [1:0]  m_snoop, m_op, c_op;
    logic [31:0] m_addr, c_addr;
    logic [31:0] m_read, m_write, m_inval, m_rwim, m_hitm;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy <= 1'b0; m_ready <= 1'b1; m_valid <= 1'b0;
            m_snoop <= 2'd2; m_op <= 2'd0; m_addr <= 32'd0;
            m_read <= 32'd0; m_write <= 32'd0; m_inval <= 32'd0;
            m_rwim <= 32'd0; m_hitm <= 32'd0;
        end else begin
            if (force_pulse) m_write <= 32'hFFFF_FFFF;
            if (!m_busy) begin
                if (bus_req_valid) begin
                    m_busy <= 1'b1; m_ready <= 1'b0;
                    c_op <= bus_op; c_addr <= bus_addr;
                    m_resp_at <= cyc + SL +
                        (((snoop_of(bus_addr[1:0]) == 2'd1) && (bus_op == 2'd0 || bus_op == 2'd3)) ? HE : 0);
                    case (bus_op)
                        2'd0: m_read  <= sat(m_read);
                        2'd1: m_write <= sat(m_write);
                        2'd2: m_inval <= sat(m_inval);
                        default: m_rwim <= sat(m_rwim);
                    endcase
                end
            end else if (m_valid) begin
                if (rsp_ready) begin
                    m_valid <= 1'b0; m_busy <= 1'b0; m_ready <= 1'b1;
                end
            end else if (cyc == m_resp_at) begin
                m_valid <= 1'b1;
                m_snoop <= snoop_of(c_addr[1:0]);
                m_op    <= c_op;
                m_addr  <= c_addr;
                if (snoop_of(c_addr[1:0]) == 2'd1) m_hitm <= sat(m_hitm);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("bus_req_ready", 32'(bus_req_ready), 32'(m_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            check("rsp_snoop", 32'(rsp_snoop), 32'(m_snoop));
            check("rsp_op", 32'(rsp_op), 32'(m_op));
            check("rsp_addr", rsp_addr, m_addr);
            check("read_cnt", read_cnt, m_read);
            check("write_cnt", write_cnt, m_write);
            check("inval_cnt", inval_cnt, m_inval);
            check("rwim_cnt", rwim_cnt, m_rwim);
            check("hitm_cnt", hitm_cnt, m_hitm);
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; bus_req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    // Present one request for one cycle; lat = edges from accept to rsp_valid.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, output int lat);
        @(negedge clk); bus_req_valid = 1'b1; bus_op = op; bus_addr = a;
        @(negedge clk); bus_req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b1; bus_req_valid = 1'b0; bus_op = 2'd0; bus_addr = 32'd0; rsp_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus_req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_snoop", 32'(rsp_snoop), 32'd2);
        check("rst_addr", rsp_addr, 32'd0);
        check("rst_read_cnt", read_cnt, 32'd0);
        rst = 1'b0;
        check_en = 1'b1;

        // READ hit, ready held high
        issue(2'd0, 32'h0000_1000, lat);
        check("read_hit_lat", 32'(lat), 32'd2);
        check("read_hit_snoop", 32'(rsp_snoop), 32'd0);
        check("read_hit_cnt", read_cnt, 32'd1);
        @(negedge clk);
        check("read_hit_idle", 32'(bus_req_ready), 32'd1);

        // READ dirty hit triggers write-back
        do_reset();
        issue(2'd0, 32'h0000_1001, lat);
        check("read_hitm_lat", 32'(lat), 32'd6);
        check("read_hitm_snoop", 32'(rsp_snoop), 32'd1);
        check("read_hitm_hitm_cnt", hitm_cnt, 32'd1);

        // WRITE dirty hit: no write-back
        do_reset();
        issue(2'd1, 32'h0000_2001, lat);
        check("write_hitm_lat", 32'(lat), 32'd2);
        check("write_hitm_snoop", 32'(rsp_snoop), 32'd1);
        check("write_hitm_wcnt", write_cnt, 32'd1);
        check("write_hitm_hcnt", hitm_cnt, 32'd1);

        // RWIM with back-pressure; competing request must be ignored
        do_reset();
        rsp_ready = 1'b0;
        issue(2'd3, 32'h0000_3002, lat);
        check("rwim_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_req_valid = 1'b1; bus_op = 2'd0; bus_addr = 32'h0000_0040;
            check("rwim_hold_valid", 32'(rsp_valid), 32'd1);
            check("rwim_hold_addr", rsp_addr, 32'h0000_3002);
            check("rwim_hold_snoop", 32'(rsp_snoop), 32'd2);
            check("rwim_hold_ready", 32'(bus_req_ready), 32'd0);
        end
        @(negedge clk); bus_req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check("rwim_done_ready", 32'(bus_req_ready), 32'd1);
        check("rwim_done_read_cnt", read_cnt, 32'd0);
        check("rwim_done_rwim_cnt", rwim_cnt, 32'd1);

        // Reset during WRITEBACK abandons the operation
        do_reset();
        @(negedge clk); bus_req_valid = 1'b1; bus_op = 2'd0; bus_addr = 32'h0000_1001;
        @(negedge clk); bus_req_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(bus_req_ready), 32'd1);
        check("abort_read_cnt", read_cnt, 32'd0);
        check("abort_hitm_cnt", hitm_cnt, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // write_cnt saturation
        do_reset();
        @(negedge clk);
        check_en = 1'b0;
        force dut.write_cnt = 32'hFFFF_FFFF;
        force_pulse = 1'b1;
        @(negedge clk);
        force_pulse = 1'b0;
        release dut.write_cnt;
        check_en = 1'b1;
        issue(2'd1, 32'h0000_2000, lat);
        check("sat_write_cnt", write_cnt, 32'hFFFF_FFFF);
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 149) == 0);
            bus_req_valid = ($urandom_range(0, 2) == 0);
            bus_op        = 2'($urandom_range(0, 3));
            bus_addr      = $urandom;
            rsp_ready     = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        rst = 1'b0; bus_req_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/bus_snoop_responder.md
BUS_SNOOP_RESPONDER -- requirements
Module: bus_snoop_responder

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_BITS, default 32, bus address width.
- SNOOP_LATENCY, default 2, cycles spent in SNOOP (legal range 1..15).
- HITM_EXTRA, default 4, extra write-back cycles on HITM (legal range 1..15).

REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- bus_req_valid  in  1  LLC presents a bus operation.
- bus_req_ready  out  1  responder can accept a request.
- bus_op  in  2  operation: READ=0, WRITE=1, INVALIDATE=2, RWIM=3.
- bus_addr  in  ADDR_BITS  operation address.
- rsp_valid  out  1  snoop result available.
- rsp_ready  in  1  LLC consumes the result.
- rsp_snoop  out  2  result: HIT=0, HITM=1, NOHIT=2.
- rsp_op  out  2  captured operation.
- rsp_addr  out  ADDR_BITS  captured address.
- read_cnt, write_cnt, inval_cnt, rwim_cnt, hitm_cnt  out  32 each  statistics counters.

Function
REQ-003 The block SHALL implement the FSM states IDLE, SNOOP, WRITEBACK and RESPOND, encoded in 2 bits.

REQ-004 bus_req_ready SHALL be 1 only in IDLE and SHALL be a registered state decode, not combinational from inputs.

REQ-005 In IDLE, when bus_req_valid=1 at a rising edge, the block SHALL capture bus_op and bus_addr, load the cycle counter with SNOOP_LATENCY-1, and go to SNOOP.

REQ-006 In SNOOP, the counter SHALL decrement each cycle. When it reaches 0, the block SHALL register rsp_snoop from the captured addr[1:0]: 00 gives HIT, 01 gives HITM, 10 and 11 give NOHIT.

REQ-007 When the SNOOP counter reaches 0, the next state SHALL be:
- WRITEBACK, with the counter loaded to HITM_EXTRA-1, if the result is HITM and the captured op is READ or RWIM.
- RESPOND otherwise, including WRITE and INVALIDATE with HITM.

REQ-008 In WRITEBACK, the counter SHALL decrement each cycle, and the block SHALL go to RESPOND when it reaches 0.

REQ-009 In RESPOND, rsp_valid SHALL be 1. rsp_snoop, rsp_op and rsp_addr SHALL stay stable until a cycle with rsp_ready=1, after which the next state SHALL be IDLE.

REQ-010 Latency from the accepting edge T to rsp_valid=1 SHALL be:
- SNOOP_LATENCY cycles without write-back.
- SNOOP_LATENCY+HITM_EXTRA cycles with write-back.

REQ-011 rsp_ready while rsp_valid=0 SHALL be ignored. bus_req_valid outside IDLE SHALL be ignored, and the request is not captured.

REQ-012 If rsp_ready=1 is already high when RESPOND is entered, the handshake SHALL complete in that first RESPOND cycle.

REQ-013 The minimum request-to-request spacing SHALL be SNOOP_LATENCY+2 cycles: a new acceptance is possible at the first IDLE cycle after the RESPOND handshake.

REQ-014 Counter updates:
- read_cnt, write_cnt, inval_cnt and rwim_cnt SHALL each increment by 1 at the accepting edge for the matching op.
- hitm_cnt SHALL increment by 1 on the edge that enters RESPOND with rsp_snoop=HITM, for any op.

REQ-015 All counters SHALL saturate at 32'hFFFF_FFFF and never wrap.

REQ-016 rsp_snoop, rsp_op and rsp_addr SHALL be don't-care-free: they hold their last values outside RESPOND.

Reset
REQ-017 While rst=1 at a rising edge, the block SHALL set:
- state to IDLE.
- bus_req_ready to 1.
- rsp_valid to 0.
- rsp_snoop to NOHIT.
- rsp_op to 0.
- rsp_addr to 0.
- the cycle counter to 0.
- all five statistics counters to 0.

REQ-018 rst SHALL override all other inputs, including a simultaneous bus_req_valid.

REQ-019 A rst asserted in SNOOP, WRITEBACK or RESPOND SHALL abandon the operation with no response and no hitm_cnt update. Counters already incremented SHALL clear to 0.

REQ-020 The first acceptance after reset SHALL be possible in the cycle after rst deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios (defaults: SNOOP_LATENCY=2, HITM_EXTRA=4):
- READ, addr=32'h0000_1000, rsp_ready held at 1 -> rsp_valid 2 cycles after accept, rsp_snoop=HIT, read_cnt=1, then IDLE.
- READ, addr=32'h0000_1001 -> rsp_valid 6 cycles after accept, rsp_snoop=HITM, hitm_cnt=1.
- WRITE, addr=32'h0000_2001 -> no WRITEBACK, rsp_valid after 2 cycles with HITM; write_cnt=1, hitm_cnt=1.
- RWIM, addr=32'h0000_3002, rsp_ready held at 0 for 5 cycles -> rsp_valid and rsp_addr stable for all 5 cycles, rsp_snoop=NOHIT, bus_req_ready=0 and a second request ignored until the handshake.
- rst pulsed while in WRITEBACK -> next cycle rsp_valid=0, bus_req_ready=1, all counters 0, no response ever issued.
- write_cnt forced to 32'hFFFF_FFFF, then one WRITE -> write_cnt remains 32'hFFFF_FFFF.
